// File: rtl/pwm_carrier_bank_if.sv
// Carrier bank bus: shadowed configuration in, carriers/dir/maskevent out.
// master = register file / comparator side, slave = carrier bank.
interface pwm_carrier_bank_if #(
  parameter int N_CARR = 4,
  parameter int CNT_W  = 16,
  parameter int EVT_W  = 4,
  parameter int DIV_W  = 8
) ();

  // configuration (all shadowed except pwm_on)
  logic [CNT_W-1:0]        period;
  logic [N_CARR*CNT_W-1:0] init_carr;
  logic [1:0]              count_mode;
  logic [1:0]              mask_mode;
  logic [EVT_W-1:0]        event_cnt;
  logic [DIV_W-1:0]        clk_div;
  logic                    clkdiv_on;
  logic                    carr_on;
  logic                    pwm_on;

  // carrier outputs
  logic [N_CARR*CNT_W-1:0] carrier;
  logic [N_CARR-1:0]       carr_dir;
  logic                    maskevent;

  modport master (
    output period,
    output init_carr,
    output count_mode,
    output mask_mode,
    output event_cnt,
    output clk_div,
    output clkdiv_on,
    output carr_on,
    output pwm_on,
    input  carrier,
    input  carr_dir,
    input  maskevent
  );

  modport slave (
    input  period,
    input  init_carr,
    input  count_mode,
    input  mask_mode,
    input  event_cnt,
    input  clk_div,
    input  clkdiv_on,
    input  carr_on,
    input  pwm_on,
    output carrier,
    output carr_dir,
    output maskevent
  );

endinterface

// File: rtl/pwm_carrier_bank.sv
// N_CARR phase-shifted PWM carriers with shared period, mode and divider.
// Ports: clk, reset (sync, active-low), bus (slave: config in, carriers out).
module pwm_carrier_bank #(
  parameter int N_CARR = 4,
  parameter int CNT_W  = 16,
  parameter int EVT_W  = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  pwm_carrier_bank_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_UPDN = 2'b10;

  state_t state;
  state_t state_nxt;

  // shadow copies of the configuration
  cnt_t             period_s;
  logic [1:0]       mode_s;
  logic [1:0]       mask_s;
  logic [EVT_W-1:0] evt_s;
  logic [DIV_W-1:0] div_s;
  logic             divon_s;
  logic             carron_s;

  // running state
  cnt_t              carr_q [N_CARR];
  cnt_t              carr_d [N_CARR];
  logic [N_CARR-1:0] dir_q;
  logic [N_CARR-1:0] dir_d;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [EVT_W-1:0]  presc_q;
  logic [EVT_W-1:0]  presc_d;
  logic              mev_q;
  logic              mev_d;

  logic tick;
  logic raw_evt;
  logic load_shadow;

  logic [N_CARR*CNT_W-1:0] carr_flat;

  // start value is clamped so a carrier never begins above the peak
  function automatic cnt_t clamp(
    input cnt_t v,
    input cnt_t p
  );
    return (v > p) ? p : v;
  endfunction

  // one carrier step; returns {dir, value}
  function automatic logic [CNT_W:0] step(
    input cnt_t       c,
    input logic       d,
    input logic [1:0] m,
    input cnt_t       p
  );
    cnt_t nc;
    logic nd;
    nc = c;
    nd = d;
    unique case (1'b1)
      m == M_UP: begin
        nd = 1'b0;
        nc = (c >= p) ? '0 : c + 1'b1;
      end
      m == M_DOWN: begin
        nd = 1'b1;
        if (c == '0 || c > p)
          nc = p;
        else
          nc = c - 1'b1;
      end
      m == M_UPDN: begin
        if (p == '0) begin
          nc = '0;
          nd = 1'b0;
        end else if (!d) begin
          if (c >= p) begin
            nc = c - 1'b1;
            nd = 1'b1;
          end else begin
            nc = c + 1'b1;
          end
        end else begin
          if (c == '0) begin
            nc = cnt_t'(1);
            nd = 1'b0;
          end else begin
            nc = c - 1'b1;
          end
        end
      end
      default: begin
        nc = c;
        nd = d;
      end
    endcase
    return {nd, nc};
  endfunction

  // next-state and datapath
  always_comb begin
    state_nxt = state;
    carr_d    = carr_q;
    dir_d     = dir_q;
    div_d     = div_q;
    presc_d   = presc_q;
    mev_d     = 1'b0;
    tick      = 1'b0;
    raw_evt   = 1'b0;

    unique case (state)
      IDLE: begin
        for (int k = 0; k < N_CARR; k++)
          carr_d[k] = '0;
        dir_d   = '0;
        div_d   = '0;
        presc_d = '0;
        if (bus.pwm_on) begin
          state_nxt = RUN;
          // shadows copy the live inputs on this same edge,
          // so start values come straight from the bus
          for (int k = 0; k < N_CARR; k++) begin
            carr_d[k] = clamp(
              bus.init_carr[k*CNT_W +: CNT_W],
              bus.period);
            dir_d[k] = (bus.count_mode == M_DOWN);
          end
        end
      end

      RUN: begin
        if (!bus.pwm_on) begin
          state_nxt = IDLE;
          for (int k = 0; k < N_CARR; k++)
            carr_d[k] = '0;
          dir_d   = '0;
          div_d   = '0;
          presc_d = '0;
        end else if (carron_s) begin
          tick = !divon_s || (div_q == div_s);
          if (!divon_s || div_q == div_s)
            div_d = '0;
          else
            div_d = div_q + 1'b1;

          if (tick) begin
            for (int k = 0; k < N_CARR; k++)
              {dir_d[k], carr_d[k]} = step(
                carr_q[k], dir_q[k], mode_s, period_s);

            raw_evt =
              (mask_s[0] && carr_d[0] == '0) ||
              (mask_s[1] && carr_d[0] == period_s);

            // prescaler above a newly lowered
            // event_cnt runs on until it wraps
            if (raw_evt) begin
              if (presc_q == evt_s) begin
                mev_d   = 1'b1;
                presc_d = '0;
              end else begin
                presc_d = presc_q + 1'b1;
              end
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // shadows track the bus while idle and
  // reload on the edge that ends a maskevent
  assign load_shadow = (state == IDLE) || mev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      period_s <= '0;
      mode_s   <= '0;
      mask_s   <= '0;
      evt_s    <= '0;
      div_s    <= '0;
      divon_s  <= 1'b0;
      carron_s <= 1'b0;
      for (int k = 0; k < N_CARR; k++)
        carr_q[k] <= '0;
      dir_q    <= '0;
      div_q    <= '0;
      presc_q  <= '0;
      mev_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (load_shadow) begin
        period_s <= bus.period;
        mode_s   <= bus.count_mode;
        mask_s   <= bus.mask_mode;
        evt_s    <= bus.event_cnt;
        div_s    <= bus.clk_div;
        divon_s  <= bus.clkdiv_on;
        carron_s <= bus.carr_on;
      end
      for (int k = 0; k < N_CARR; k++)
        carr_q[k] <= carr_d[k];
      dir_q    <= dir_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      mev_q    <= mev_d;
    end
  end

  always_comb begin
    carr_flat = '0;
    for (int k = 0; k < N_CARR; k++)
      carr_flat[k*CNT_W +: CNT_W] = carr_q[k];
  end

  assign bus.carrier   = carr_flat;
  assign bus.carr_dir  = dir_q;
  assign bus.maskevent = mev_q;

endmodule

// File: tb/tb_pwm_carrier_bank.sv
// Directed bench for pwm_carrier_bank: sawtooth, triangle, divider,
// freeze, live period change, stop/restart/reset and down mode.
module tb_pwm_carrier_bank;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pwm_carrier_bank_if #(
    .N_CARR(4), .CNT_W(16), .EVT_W(4), .DIV_W(8)
  ) bus ();

  pwm_carrier_bank #(
    .N_CARR(4), .CNT_W(16), .EVT_W(4), .DIV_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] ch(input int k);
    return bus.carrier[k*16 +: 16];
  endfunction

  task automatic cfg(
    input logic [15:0] p,
    input logic [63:0] init,
    input logic [1:0]  mode,
    input logic [1:0]  mask,
    input logic [3:0]  evt,
    input logic [7:0]  div,
    input logic        divon
  );
    bus.period     = p;
    bus.init_carr  = init;
    bus.count_mode = mode;
    bus.mask_mode  = mask;
    bus.event_cnt  = evt;
    bus.clk_div    = div;
    bus.clkdiv_on  = divon;
    bus.carr_on    = 1'b1;
  endtask

  task automatic restart();
    bus.pwm_on = 1'b1;
    cyc(1);
  endtask

  task automatic stop();
    bus.pwm_on = 1'b0;
    cyc(1);
  endtask

  int exp_v;

  initial begin
    cfg(16'd0, 64'd0, 2'b00, 2'b00, 4'd0, 8'd0, 1'b0);
    bus.pwm_on = 1'b0;
    reset = 1'b0;
    cyc(2);
    chk("rst carrier", bus.carrier, 64'd0);
    chk("rst dir", bus.carr_dir, 0);
    chk("rst mev", bus.maskevent, 0);
    reset = 1'b1;
    cyc(1);

    // sawtooth P=9, phases 0/3/6/9, maskevent on ch0 wrap
    cfg(16'd9, {16'd9, 16'd6, 16'd3, 16'd0},
        2'b00, 2'b01, 4'd0, 8'd0, 1'b0);
    restart();
    for (int k = 0; k < 4; k++)
      chk($sformatf("t1 init ch%0d", k), ch(k), 3 * k);
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      for (int k = 0; k < 4; k++)
        chk($sformatf("t1 ch%0d n%0d", k, n), ch(k),
            (3 * k + n) % 10);
      chk($sformatf("t1 mev n%0d", n), bus.maskevent,
          (n % 10) == 0);
      chk($sformatf("t1 dir n%0d", n), bus.carr_dir, 0);
    end

    // stop mid-period, re-enable, reset mid-run
    cyc(3);
    chk("t5 ch0 before stop", ch(0), 3);
    bus.pwm_on = 1'b0;
    cyc(1);
    chk("t5 stop carrier", bus.carrier, 64'd0);
    chk("t5 stop mev", bus.maskevent, 0);
    bus.pwm_on = 1'b1;
    cyc(1);
    chk("t5 reload ch1", ch(1), 3);
    chk("t5 reload ch3", ch(3), 9);
    cyc(2);
    chk("t5 run ch0", ch(0), 2);
    reset = 1'b0;
    cyc(1);
    chk("t5 reset carrier", bus.carrier, 64'd0);
    chk("t5 reset dir", bus.carr_dir, 0);
    reset = 1'b1;
    bus.pwm_on = 1'b0;
    cyc(1);

    // clamp and live period change, applied after maskevent
    cfg(16'd9, {16'd0, 16'd0, 16'd15, 16'd0},
        2'b00, 2'b01, 4'd0, 8'd0, 1'b0);
    restart();
    chk("t4 clamp ch1", ch(1), 9);
    chk("t4 ch0 start", ch(0), 0);
    cyc(2);
    bus.period = 16'd20;
    cyc(7);
    chk("t4 ch0 n9", ch(0), 9);
    cyc(1);
    chk("t4 ch0 n10", ch(0), 0);
    chk("t4 mev n10", bus.maskevent, 1);
    cyc(1);
    chk("t4 ch0 n11", ch(0), 1);
    chk("t4 ch1 old P n11", ch(1), 0);
    cyc(9);
    chk("t4 ch0 n20", ch(0), 10);
    cyc(10);
    chk("t4 ch0 n30", ch(0), 20);
    chk("t4 mev n30", bus.maskevent, 0);
    cyc(1);
    chk("t4 ch0 n31", ch(0), 0);
    chk("t4 ch1 n31", ch(1), 20);
    chk("t4 mev n31", bus.maskevent, 1);
    stop();

    // up-down P=4, both masks, every 2nd raw event
    cfg(16'd4, 64'd0, 2'b10, 2'b11, 4'd1, 8'd0, 1'b0);
    restart();
    chk("t2 ch0 start", ch(0), 0);
    for (int n = 1; n <= 16; n++) begin
      cyc(1);
      exp_v = (n % 8 <= 4) ? n % 8 : 8 - n % 8;
      chk($sformatf("t2 ch0 n%0d", n), ch(0), exp_v);
      chk($sformatf("t2 dir n%0d", n), bus.carr_dir[0],
          (n % 8 >= 5) || (n % 8 == 0));
      chk($sformatf("t2 mev n%0d", n), bus.maskevent,
          (n % 8) == 0);
    end
    stop();

    // divider clk_div=2, then freeze via carr_on
    cfg(16'd3, 64'd0, 2'b00, 2'b10, 4'd0, 8'd2, 1'b1);
    restart();
    for (int n = 1; n <= 9; n++) begin
      cyc(1);
      chk($sformatf("t3 ch0 n%0d", n), ch(0), (n / 3) % 4);
      chk($sformatf("t3 mev n%0d", n), bus.maskevent, n == 9);
      if (n == 5)
        bus.carr_on = 1'b0;
    end
    for (int n = 10; n <= 20; n++) begin
      cyc(1);
      chk($sformatf("t3 frozen n%0d", n), ch(0), 3);
      chk($sformatf("t3 frozen mev n%0d", n), bus.maskevent, 0);
    end
    stop();

    // down mode P=5, maskevent at reload to P
    cfg(16'd5, {16'd0, 16'd0, 16'd0, 16'd5},
        2'b01, 2'b10, 4'd0, 8'd0, 1'b0);
    restart();
    chk("t6 ch0 start", ch(0), 5);
    chk("t6 dir start", bus.carr_dir[0], 1);
    for (int n = 1; n <= 12; n++) begin
      cyc(1);
      chk($sformatf("t6 ch0 n%0d", n), ch(0), 5 - n % 6);
      chk($sformatf("t6 dir n%0d", n), bus.carr_dir[0], 1);
      chk($sformatf("t6 mev n%0d", n), bus.maskevent,
          (n % 6) == 0);
    end
    stop();
    chk("end idle carrier", bus.carrier, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
